// File: rtl/mul_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul_job_sequencer
// Brief    : Queues operand pairs, issues one job at a time to a shift-add
//            multiplier, captures the product and flags a missing completion.
// Revision : 1.0
// ============================================================================
module mul_job_sequencer #(
    parameter int N       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4 * N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_b,
    input  logic [N-1:0]     in_q,
    output logic             mul_start,
    output logic [N-1:0]     mul_b,
    output logic [N-1:0]     mul_q,
    input  logic             mul_stop,
    input  logic [2*N-1:0]   mul_a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_p,
    output logic             busy,
    output logic             err_timeout
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(TIMEOUT + 1);

    localparam logic [c_AW:0]   c_PTR_ONE = (c_AW + 1)'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(TIMEOUT - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_LAUNCH = 3'd1;
    localparam logic [2:0] c_S_GUARD  = 3'd2;
    localparam logic [2:0] c_S_WAIT   = 3'd3;
    localparam logic [2:0] c_S_HOLD   = 3'd4;
    localparam logic [2:0] c_S_FAULT  = 3'd5;

    logic [2*N-1:0]  r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [N-1:0]    r_mul_b;
    logic [N-1:0]    r_mul_q;
    logic [2*N-1:0]  r_out_p;
    logic            r_err;

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_capture;
    logic            w_set_err;
    logic [2*N-1:0]  w_head;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push  = in_valid && in_ready;
    assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

    assign in_ready    = !w_full && (r_state != c_S_FAULT);
    assign mul_start   = (r_state == c_S_LAUNCH);
    assign out_valid   = (r_state == c_S_HOLD);
    assign busy        = (r_state != c_S_IDLE);
    assign mul_b       = r_mul_b;
    assign mul_q       = r_mul_q;
    assign out_p       = r_out_p;
    assign err_timeout = r_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {in_b, in_q};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_S_LAUNCH;
                end
            end
            c_S_LAUNCH: w_state_nxt = c_S_GUARD;
            // A stop left high by the previous job is not trusted here.
            c_S_GUARD:  w_state_nxt = c_S_WAIT;
            c_S_WAIT: begin
                if (mul_stop) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_S_HOLD;
                end else if (r_cnt == c_TO_LAST) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = c_S_FAULT;
                end
            end
            c_S_HOLD: begin
                if (out_ready) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = c_S_LAUNCH;
                    end else begin
                        w_state_nxt = c_S_IDLE;
                    end
                end
            end
            c_S_FAULT:  w_state_nxt = c_S_FAULT;
            default:    w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_mul_b  <= '0;
            r_mul_q  <= '0;
            r_out_p  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_mul_b  <= w_head[2*N-1:N];
                r_mul_q  <= w_head[N-1:0];
            end
            if (r_state == c_S_GUARD) begin
                r_cnt <= '0;
            end else if (r_state == c_S_WAIT) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            if (w_capture) begin
                r_out_p <= mul_a;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_job_sequencer
// Brief    : Directed bench for mul_job_sequencer with a behavioural multiplier.
// Revision : 1.0
// ============================================================================
module tb_mul_job_sequencer;

    localparam int TIMEOUT = 32;

    logic        clk = 1'b1;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_b = '0;
    logic [7:0]  in_q = '0;
    logic        mul_start;
    logic [7:0]  mul_b;
    logic [7:0]  mul_q;
    logic        mul_stop = 1'b0;
    logic [15:0] mul_a = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_p;
    logic        busy;
    logic        err_timeout;

    int vectors = 0;
    int miscompares = 0;

    int          model_mode = 0;   // 0 normal, 1 stale stop, 2 never stops
    int          m_cnt = 0;
    logic        m_phase = 1'b0;
    logic [7:0]  m_b = '0;
    logic [7:0]  m_q = '0;

    int          start_cnt = 0;
    logic [15:0] results[$];
    logic        watch_busy = 1'b0;
    int          busy_gap = 0;

    mul_job_sequencer #(.N(8), .DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_b(in_b), .in_q(in_q),
        .mul_start(mul_start), .mul_b(mul_b), .mul_q(mul_q),
        .mul_stop(mul_stop), .mul_a(mul_a),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: stop rises 8 edges after start and stays high.
    always @(posedge clk) begin
        if (mul_start) begin
            m_b <= mul_b;
            m_q <= mul_q;
            if (model_mode == 1) begin
                mul_stop <= 1'b1;
                mul_a    <= 16'hDEAD;
                m_phase  <= 1'b1;
                m_cnt    <= 0;
            end else begin
                mul_stop <= 1'b0;
                m_phase  <= 1'b0;
                m_cnt    <= (model_mode == 2) ? 0 : 8;
            end
        end else if (m_phase) begin
            m_phase  <= 1'b0;
            mul_stop <= 1'b0;
            m_cnt    <= 8;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mul_stop <= 1'b1;
                mul_a    <= 16'(m_b) * 16'(m_q);
            end
        end
    end

    always @(posedge clk) begin
        if (mul_start) start_cnt <= start_cnt + 1;
        if (out_valid && out_ready) results.push_back(out_p);
    end

    always @(negedge clk) begin
        if (watch_busy && !busy) busy_gap <= busy_gap + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic [7:0] q);
        in_valid = 1'b1;
        in_b = b;
        in_q = q;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_for_start(input string tag);
        int n = 0;
        while (!mul_start && n < 50) begin step(); n++; end
        check(tag, mul_start, 1);
    endtask

    task automatic wait_for_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 100) begin step(); n++; end
        check(tag, out_valid, 1);
    endtask

    task automatic wait_results(input string tag, input int target);
        int n = 0;
        while (results.size() < target && n < 400) begin step(); n++; end
        check(tag, results.size(), target);
    endtask

    logic [7:0]  fb [5] = '{8'h03, 8'h10, 8'h0A, 8'hFF, 8'h07};
    logic [7:0]  fq [5] = '{8'h05, 8'h10, 8'h0B, 8'h01, 8'h07};
    logic        frdy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] fexp [5] = '{16'h0006, 16'h000F, 16'h0100, 16'h006E, 16'h00FF};

    initial begin
        int base;
        int sbase;
        int gbase;

        // Reset values
        #20;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_mul_q", mul_q, 0);
        check("rst_out_p", out_p, 0);
        check("rst_err", err_timeout, 0);
        #65 reset = 1'b0;
        step();

        // Single job
        push(8'h0F, 8'h0E);
        wait_for_start("t1_start");
        check("t1_mul_b", mul_b, 8'h0F);
        check("t1_mul_q", mul_q, 8'h0E);
        step();
        check("t1_start_pulse", mul_start, 0);
        check("t1_busy", busy, 1);
        wait_for_valid("t1_valid");
        check("t1_out_p", out_p, 16'h00D2);
        step(); step(); step();
        check("t1_valid_held", out_valid, 1);
        check("t1_out_p_held", out_p, 16'h00D2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t1_valid_drop", out_valid, 0);
        check("t1_idle", busy, 0);
        check("t1_result_cnt", results.size(), 1);

        // Back-to-back with out_ready tied high
        out_ready = 1'b1;
        base  = results.size();
        sbase = start_cnt;
        gbase = busy_gap;
        push(8'hFF, 8'hFF);
        push(8'h00, 8'h37);
        push(8'h01, 8'h80);
        watch_busy = 1'b1;
        wait_results("t2_count", base + 3);
        watch_busy = 1'b0;
        check("t2_p0", results[base], 16'hFE01);
        check("t2_p1", results[base+1], 16'h0000);
        check("t2_p2", results[base+2], 16'h0080);
        check("t2_starts", start_cnt - sbase, 3);
        check("t2_busy_gap", busy_gap - gbase, 0);
        step();
        check("t2_idle", busy, 0);

        // Full FIFO while the FSM waits in HOLD
        out_ready = 1'b0;
        base = results.size();
        push(8'h02, 8'h03);
        wait_for_valid("t3_hold");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_b = fb[i];
            in_q = fq[i];
            check($sformatf("t3_in_ready%0d", i), in_ready, frdy[i]);
            step();
        end
        in_valid = 1'b0;
        check("t3_full", in_ready, 0);
        out_ready = 1'b1;
        wait_results("t3_count", base + 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_p%0d", i), results[base+i], fexp[i]);
        end
        repeat (30) step();
        check("t3_no_extra", results.size(), base + 5);
        check("t3_idle", busy, 0);

        // Stale stop held through LAUNCH/GUARD
        base = results.size();
        check("t4_stop_pre", mul_stop, 1);
        model_mode = 1;
        push(8'h0C, 8'h0D);
        wait_results("t4_count", base + 1);
        check("t4_p", results[base], 16'h009C);
        model_mode = 0;

        // Timeout
        model_mode = 2;
        push(8'h05, 8'h05);
        wait_for_start("t5_start");
        step();
        step();
        repeat (TIMEOUT - 1) step();
        check("t5_err_early", err_timeout, 0);
        step();
        check("t5_err", err_timeout, 1);
        check("t5_busy", busy, 1);
        check("t5_in_ready", in_ready, 0);
        check("t5_out_valid", out_valid, 0);
        check("t5_mul_start", mul_start, 0);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_err", err_timeout, 0);
        check("t5_rst_in_ready", in_ready, 1);
        check("t5_rst_busy", busy, 0);
        #3 reset = 1'b0;
        model_mode = 0;
        step();
        base = results.size();
        push(8'h06, 8'h07);
        wait_results("t5_resume", base + 1);
        check("t5_resume_p", results[base], 16'h002A);

        // Asynchronous reset during WAIT
        out_ready = 1'b0;
        push(8'h09, 8'h09);
        wait_for_start("t6_start");
        push(8'h02, 8'h02);
        step(); step();
        check("t6_busy_pre", busy, 1);
        base  = results.size();
        sbase = start_cnt;
        #3 reset = 1'b1;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_mul_start", mul_start, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_mul_b", mul_b, 0);
        #3 reset = 1'b0;
        step();
        out_ready = 1'b1;
        repeat (30) step();
        check("t6_no_start", start_cnt - sbase, 0);
        check("t6_no_result", results.size(), base);
        check("t6_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mul_job_sequencer.md
Name: mul_job_sequencer

Overview:
- Sits directly upstream of the shift-add multiplier (ports clk, reset, start, b_in, q_in, stop, a_out) and drives its start/operand inputs.
- Buffers operand pairs from a producer in a small FIFO and issues one multiply job at a time.
- Captures each product when the multiplier signals stop and presents it on a valid/ready result port.
- Flags a timeout if the multiplier never completes.

Parameters:
- N, 8, operand width; product width is 2*N.
- DEPTH, 4, operand FIFO depth; power of 2, at least 2.
- TIMEOUT, 4*N, maximum cycles to wait for mul_stop before declaring an error.

Ports:
- clk  in  1  system clock; all logic is rising-edge triggered.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has an operand pair on in_b/in_q.
- in_ready  out  1  FIFO not full; the pair is accepted when in_valid && in_ready.
- in_b  in  N  multiplicand.
- in_q  in  N  multiplier.
- mul_start  out  1  start pulse to the multiplier.
- mul_b  out  N  to multiplier b_in.
- mul_q  out  N  to multiplier q_in.
- mul_stop  in  1  multiplier done flag.
- mul_a  in  2N  multiplier a_out.
- out_valid  out  1  product held on out_p.
- out_ready  in  1  consumer accepts; transfer happens when out_valid && out_ready.
- out_p  out  2N  captured product.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async, level-active): FIFO emptied; state IDLE; all outputs 0 except in_ready=1; mul_b, mul_q and out_p are 0.
- FIFO:
  - DEPTH entries, registered write/read pointers with one extra wrap bit.
  - in_ready = !full.
  - Simultaneous push and pop while full is not allowed, because in_ready is 0 when full. Simultaneous push and pop at any other occupancy keeps the count unchanged.
  - A push into an empty FIFO becomes visible to the FSM on the next cycle. There is no fall-through.
- FSM states: IDLE, LAUNCH, GUARD, WAIT, HOLD, FAULT.
  - IDLE: if the FIFO is not empty, pop the head into mul_b/mul_q registers and go to LAUNCH.
  - LAUNCH:
    - mul_start=1 for exactly one cycle; mul_b/mul_q stay stable from this cycle through the end of WAIT.
    - Go to GUARD.
  - GUARD:
    - One cycle; mul_stop is ignored here, because a stale stop from the previous job may still be high.
    - Clear the timeout counter and go to WAIT.
  - WAIT:
    - Timeout counter increments each cycle.
    - If mul_stop=1: capture mul_a into out_p, set out_valid=1, go to HOLD.
    - Else if counter reaches TIMEOUT-1: set err_timeout=1, go to FAULT.
  - HOLD:
    - out_valid=1 and out_p is stable until out_ready=1.
    - On the handshake cycle, out_valid drops next cycle. If the FIFO is not empty, pop and go directly to LAUNCH, else go to IDLE.
  - FAULT:
    - Terminal. in_ready=0, mul_start=0, out_valid=0, busy=1.
    - Exit only by reset.
- Latency: a push into an empty FIFO with an idle FSM produces mul_start 2 cycles after the push edge (pop edge, then LAUNCH). out_valid rises on the edge after the first WAIT cycle that sees mul_stop=1.
- Throughput: one job in flight; minimum of 4 cycles per job plus the multiplier compute time.
- Reset mid-operation:
  - Immediate return to reset values.
  - Queued and in-flight jobs are discarded; there is no partial product output.
- Width rule: out_p is exactly mul_a, 2N bits, with no truncation.

Test Plan:
- Single job: reset high 0–85 ns, push b=8'h0F, q=8'h0E. Expect mul_start high one cycle with mul_b=0F and mul_q=0E. Model the multiplier to return 16'h00D2 with stop after 8 cycles. Expect out_p=16'h00D2, out_valid=1 until out_ready.
- Back-to-back: push (FF,FF), (00,37), (01,80) in consecutive cycles with out_ready tied to 1. Expect products FE01, 0000, 0080 in order. Expect exactly 3 mul_start pulses and busy held high throughout.
- Full FIFO: hold the FSM in HOLD (out_ready=0) and push DEPTH+1 pairs. Expect in_ready=0 after DEPTH pushes have been accepted and the extra pair not accepted. Release out_ready and expect every queued job to drain in order.
- Stale stop: the multiplier model holds stop=1 through LAUNCH/GUARD, deasserts it, then reasserts it 8 cycles later. Expect capture only on the reasserted stop, with the correct product.
- Timeout: the model never asserts stop. Expect err_timeout=1 exactly TIMEOUT cycles after GUARD, state FAULT, and in_ready=0. Apply reset and expect err_timeout=0, in_ready=1, and normal operation resuming.
- Async reset mid-WAIT: assert reset between clock edges during WAIT. Expect out_valid=0, busy=0, mul_start=0 immediately, and the FIFO empty (no mul_start after reset is released).
